// File: rtl/decodif_morse_pkg.sv
// Shared definitions for the Morse receive path.
//   state_t      : FSM state encoding (IDLE, MARK, SPACE, DONE)
//   COD_INVALID  : character code reported for unusable patterns
//   LETTER_OFFSET: code of 'A'; digits occupy 0..9
//   MAX_SYMS     : longest pattern (digits use all five positions)
//   morse_entry  : pattern/length table, pattern MSB-aligned, 1 = dash
package decodif_morse_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE, ST_DONE} state_t;

    localparam logic [5:0] COD_INVALID   = 6'd63;
    localparam int         LETTER_OFFSET = 10;
    localparam int         MAX_SYMS      = 5;
    localparam int         NUM_CODES     = 36;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } sym_t;

    function automatic sym_t morse_entry(input logic [5:0] code);
        sym_t e;
        e = '0;
        if (code < 6'(LETTER_OFFSET)) begin
            case (code)
                6'd0: e = '{3'd5, 5'b11111};
                6'd1: e = '{3'd5, 5'b01111};
                6'd2: e = '{3'd5, 5'b00111};
                6'd3: e = '{3'd5, 5'b00011};
                6'd4: e = '{3'd5, 5'b00001};
                6'd5: e = '{3'd5, 5'b00000};
                6'd6: e = '{3'd5, 5'b10000};
                6'd7: e = '{3'd5, 5'b11000};
                6'd8: e = '{3'd5, 5'b11100};
                6'd9: e = '{3'd5, 5'b11110};
                default: e = '0;
            endcase
        end else begin
            case (code - 6'(LETTER_OFFSET))
                6'd0:  e = '{3'd2, 5'b01000}; // A .-
                6'd1:  e = '{3'd4, 5'b10000}; // B -...
                6'd2:  e = '{3'd4, 5'b10100}; // C -.-.
                6'd3:  e = '{3'd3, 5'b10000}; // D -..
                6'd4:  e = '{3'd1, 5'b00000}; // E .
                6'd5:  e = '{3'd4, 5'b00100}; // F ..-.
                6'd6:  e = '{3'd3, 5'b11000}; // G --.
                6'd7:  e = '{3'd4, 5'b00000}; // H ....
                6'd8:  e = '{3'd2, 5'b00000}; // I ..
                6'd9:  e = '{3'd4, 5'b01110}; // J .---
                6'd10: e = '{3'd3, 5'b10100}; // K -.-
                6'd11: e = '{3'd4, 5'b01000}; // L .-..
                6'd12: e = '{3'd2, 5'b11000}; // M --
                6'd13: e = '{3'd2, 5'b10000}; // N -.
                6'd14: e = '{3'd3, 5'b11100}; // O ---
                6'd15: e = '{3'd4, 5'b01100}; // P .--.
                6'd16: e = '{3'd4, 5'b11010}; // Q --.-
                6'd17: e = '{3'd3, 5'b01000}; // R .-.
                6'd18: e = '{3'd3, 5'b00000}; // S ...
                6'd19: e = '{3'd1, 5'b10000}; // T -
                6'd20: e = '{3'd3, 5'b00100}; // U ..-
                6'd21: e = '{3'd4, 5'b00010}; // V ...-
                6'd22: e = '{3'd3, 5'b01100}; // W .--
                6'd23: e = '{3'd4, 5'b10010}; // X -..-
                6'd24: e = '{3'd4, 5'b10110}; // Y -.--
                6'd25: e = '{3'd4, 5'b11000}; // Z --..
                default: e = '0;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/decodif_morse_tabela.sv
// Pattern-to-code lookup for the Morse decoder.
//   morse   : received pattern, MSB-aligned, unused positions zero
//   sym_cnt : number of symbols in the pattern
//   num     : matching character code, COD_INVALID when no entry matches
//   valid   : 1 when a table entry matched
module decodif_morse_tabela
    import decodif_morse_pkg::*;
(
    input  logic [4:0] morse,
    input  logic [2:0] sym_cnt,
    output logic [5:0] num,
    output logic       valid
);

    always_comb begin : lookup
        sym_t e;
        e     = '0;
        num   = COD_INVALID;
        valid = 1'b0;
        for (int i = 0; i < NUM_CODES; i++) begin
            e = morse_entry(6'(i));
            if (e.len == sym_cnt && e.pat == morse) begin
                num   = 6'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decodif_morse.sv
// Morse receiver: synchronises the key, times marks and spaces, classifies
// marks as dot/dash and emits the character code once the gap closes.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   key     : Morse key, 1 = pressed, asynchronous
//   num     : decoded code 0..35, 63 = invalid
//   ready   : one-cycle pulse, num/morse/display valid
//   error   : one-cycle pulse with ready for an invalid pattern
//   morse   : received symbols, first in bit 4, 1 = dash
//   display : used-position mask, MSB-aligned
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | no character in progress
// ST_MARK  | key held, counting mark length
// ST_SPACE | key released, counting toward the char gap
// ST_DONE  | gap closed, publishing the character
module decodif_morse
    import decodif_morse_pkg::*;
#(
    parameter int DOT_MAX    = 4,
    parameter int MIN_MARK   = 2,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [5:0] num,
    output logic       ready,
    output logic       error,
    output logic [4:0] morse,
    output logic [4:0] display
);

    logic             key_m, key_s;
    state_t           state;
    logic [CNT_W-1:0] mark_cnt, space_cnt, mark_inc;
    logic [4:0]       shift_reg, pat_aligned, pat_mask;
    logic [2:0]       sym_cnt;
    logic             overflow, pend;
    logic [5:0]       tab_num;
    logic             tab_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
        end else begin
            key_m <= key;
            key_s <= key_m;
        end
    end

    // Shift register fills from the LSB; align so the first symbol is bit 4.
    assign pat_aligned = shift_reg << (3'(MAX_SYMS) - sym_cnt);
    assign pat_mask    = ~(5'b11111 >> sym_cnt);
    assign mark_inc    = (mark_cnt == '1) ? mark_cnt : mark_cnt + 1'b1;

    decodif_morse_tabela u_tabela (
        .morse   (pat_aligned),
        .sym_cnt (sym_cnt),
        .num     (tab_num),
        .valid   (tab_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mark_cnt  <= '0;
            space_cnt <= '0;
            shift_reg <= '0;
            sym_cnt   <= '0;
            overflow  <= 1'b0;
            pend      <= 1'b0;
            num       <= '0;
            morse     <= '0;
            display   <= '0;
            ready     <= 1'b0;
            error     <= 1'b0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_s) begin
                        state    <= ST_MARK;
                        mark_cnt <= CNT_W'(1);
                    end
                end
                ST_MARK: begin
                    if (key_s) begin
                        mark_cnt <= mark_inc;
                    end else if (mark_cnt < CNT_W'(MIN_MARK)) begin
                        state     <= (sym_cnt != 3'd0) ? ST_SPACE : ST_IDLE;
                        space_cnt <= CNT_W'(1);
                    end else begin
                        if (sym_cnt < 3'(MAX_SYMS)) begin
                            shift_reg <= {shift_reg[3:0], (mark_cnt > CNT_W'(DOT_MAX))};
                            sym_cnt   <= sym_cnt + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        state     <= ST_SPACE;
                        space_cnt <= CNT_W'(1);
                    end
                end
                ST_SPACE: begin
                    if (space_cnt + CNT_W'(1) >= CNT_W'(GAP_CYCLES)) begin
                        // A press landing on the closing cycle starts the next mark.
                        state    <= ST_DONE;
                        pend     <= key_s;
                        mark_cnt <= CNT_W'(1);
                    end else if (key_s) begin
                        state    <= ST_MARK;
                        mark_cnt <= CNT_W'(1);
                    end else begin
                        space_cnt <= space_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    if (overflow) begin
                        num     <= COD_INVALID;
                        error   <= 1'b1;
                        morse   <= 5'b11111;
                        display <= 5'b11111;
                    end else begin
                        num     <= tab_valid ? tab_num : COD_INVALID;
                        error   <= ~tab_valid;
                        morse   <= pat_aligned;
                        display <= pat_mask;
                    end
                    shift_reg <= '0;
                    sym_cnt   <= '0;
                    overflow  <= 1'b0;
                    pend      <= 1'b0;
                    if (key_s) begin
                        state    <= ST_MARK;
                        mark_cnt <= pend ? mark_inc : CNT_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/decodif_morse.md
Name: decodif_morse

Overview:
- Receive side of the Morse path: samples a single key line and measures mark and space lengths in clock cycles.
- Classifies each mark as ponto (dot) or traço (dash) and assembles up to 5 symbols.
- On an inter-character gap, emits the 6-bit character code in the same numbering the encoder consumes: 0–9 = digits, 10–35 = A–Z.
- Sits between the key/button input and the display/host logic.
- Also exports the assembled morse/display pair, so it can be looped back against codifMorse.

Parameters:
- DOT_MAX, 4: longest mark, in cycles, classified as ponto; longer marks are traço.
- MIN_MARK, 2: marks shorter than this are glitches and are discarded.
- GAP_CYCLES, 8: space length, in cycles, that closes a character.
- CNT_W, 8: width of the mark/space counters; counters saturate at all-ones.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key  in  1  Morse key, 1 = pressed; asynchronous to clk.
- num  out  6  decoded character code, 0–35; 63 = invalid.
- ready  out  1  one-cycle pulse; num/morse/display valid.
- error  out  1  one-cycle pulse, coincident with ready, for an invalid pattern.
- morse  out  5  symbol bits: 1 = traço, 0 = ponto; first symbol in bit 4, descending.
- display  out  5  used-position mask, MSB-aligned (e.g. 2 symbols = 11000).

Behaviour:
- Reset (reset=0, async): state IDLE; counters, shift register and symbol count cleared; sync flops = 0; num=0, morse=0, display=0, ready=0, error=0.
- Input sync: key passes through a 2-FF synchroniser (key_s); all timing uses key_s.
- States:
  - IDLE: key_s=1 -> MARK, mark_cnt=1.
  - MARK: mark_cnt++ (saturating) while key_s=1. On key_s=0:
    - mark_cnt < MIN_MARK: discard; go to SPACE if symbols already stored, else IDLE.
    - otherwise: shift in symbol (mark_cnt <= DOT_MAX -> 0, else 1); sym_cnt++; go to SPACE with space_cnt=1.
  - SPACE: space_cnt++ while key_s=0. key_s=1 before the gap -> MARK, mark_cnt=1, symbols kept. space_cnt reaching GAP_CYCLES -> DONE.
  - DONE (1 cycle): look up the pattern; register num/morse/display; pulse ready; clear sym_cnt/shift register; -> IDLE.
- Output timing:
  - ready is high in the cycle after DONE is entered.
  - num/morse/display hold their values until the next ready.
  - Latency from the synchronised release of the last mark to ready = GAP_CYCLES+1 cycles.
- Overflow: a 6th valid mark sets an overflow flag; symbols beyond 5 are dropped.
  - At DONE with overflow: num=63, error=1, morse=11111, display=11111.
- Unknown pattern (valid length, no table entry, e.g. "..--"): num=63, error=1; morse/display show the received pattern.
- Simultaneous events:
  - key_s rises in the same cycle space_cnt reaches GAP_CYCLES: the character closes (DONE), and the press is counted as a new mark starting that cycle (DONE -> MARK with mark_cnt=1 rather than IDLE).
- Boundary cases:
  - A mark longer than 2^CNT_W-1 saturates and is a traço.
  - A space while sym_cnt=0 never produces ready.
- Reset mid-character: aborts with no ready and no error pulse.
- Table: standard International Morse for 0–9 and A–Z. Digits are 5 symbols (1=.----, 0=-----); letters are 1–4 symbols.

Decomposition:
- Shared package morse_pkg:
  - state encoding (IDLE, MARK, SPACE, DONE);
  - code constants: COD_INVALID=63, first-letter offset 10, MAX_SYMS=5;
  - the 36-entry pattern/length table, used by both encoder and decoder.
- Sub-module morse_tabela: combinational mapping from {morse, sym_cnt} to {num, valid}. This keeps the FSM file to timing/control only.

Test Plan:
All runs use DOT_MAX=4, MIN_MARK=2, GAP_CYCLES=8; mark lengths are in key-high cycles.
- Marks of 2 then 7 cycles, 3-cycle space between, then 10 idle -> one ready pulse: num=10 (A), morse=01000, display=11000, error=0.
- Marks 3,3,3,7,7 ("...--"), 3-cycle spaces -> num=3, morse=00011, display=11111; ready exactly GAP_CYCLES+1 cycles after the synchronised final release.
- Six 3-cycle marks (one symbol too many) -> ready and error together, num=63, morse=11111, display=11111.
- A 1-cycle glitch on key, then idle -> no ready. Glitch inserted inside the "-." gap of N -> num=23 unaffected.
- reset pulled low for 1 cycle after two marks, then released -> no ready. The next "-" alone decodes to num=29 (T).
- Key pressed exactly on the cycle the gap completes after "." -> num=14 (E) ready. Then a following 7-cycle mark plus gap -> num=29.
